// File: rtl/lvds_clk_sync.sv
// Watches a slow system clock from inside the LVDS DDR domain: flags lock once it
// toggles steadily and emits a one-cycle strobe per detected rising edge while locked.
module lvds_clk_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_EDGES  = 8,
    parameter int TIMEOUT     = 32
) (
    input  logic i_ddr_clk,
    input  logic i_rst,
    input  logic i_sys_clk,
    output logic o_lvds_ready_ddr,
    output logic o_data_sbe_ddr
);

    localparam int GAP_W  = $clog2(TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCK_EDGES + 1);

    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_PRE  = GAP_W'(TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_EDGES);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   p;
    logic                   rise;
    logic                   timeout;
    logic                   lock_hit;
    logic                   sbe_nxt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [GAP_W-1:0]       gap_nxt;
    logic [LOCK_W-1:0]      lock_cnt;
    logic [LOCK_W-1:0]      lock_nxt;

    // i_sys_clk is only ever sampled as data; it never clocks anything
    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            p      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sys_clk};
            p      <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p;

    always_comb begin
        gap_nxt = gap_cnt;
        if (rise) begin
            gap_nxt = '0;
        end else if (gap_cnt < GAP_MAX) begin
            gap_nxt = gap_cnt + 1'b1;
        end
    end

    // Fires only on the TIMEOUT-1 -> TIMEOUT step, so a saturated counter stays quiet
    assign timeout = ~rise & (gap_cnt == GAP_PRE);

    always_comb begin
        lock_nxt = lock_cnt;
        if (rise) begin
            if (lock_cnt < LOCK_MAX) begin
                lock_nxt = lock_cnt + 1'b1;
            end
        end else if (timeout) begin
            lock_nxt = '0;
        end
    end

    assign lock_hit = rise & (lock_nxt == LOCK_MAX);

    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            gap_cnt  <= '0;
            lock_cnt <= '0;
        end else begin
            gap_cnt  <= gap_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (lock_hit) state_nxt = LOCKED;
            LOCKED:   if (timeout)  state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // Strobe uses the pre-update lock state, so the locking edge itself is silent
    always_comb begin
        sbe_nxt = rise & (state == LOCKED);
    end

    always_ff @(posedge i_ddr_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data_sbe_ddr <= 1'b0;
        end else begin
            o_data_sbe_ddr <= sbe_nxt;
        end
    end

    assign o_lvds_ready_ddr = (state == LOCKED);

endmodule

// File: tb/tb_lvds_clk_sync.sv
// Scoreboard bench for lvds_clk_sync: two instances (default and LOCK_EDGES=1/TIMEOUT=4)
// share one stimulus stream; an edge-timestamp reference model predicts both outputs.
module tb_lvds_clk_sync;

    localparam int S0 = 2, L0 = 8, T0 = 32;
    localparam int S1 = 3, L1 = 1, T1 = 4;
    localparam int HIST = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sys = 1'b0;
    logic rdy0, sbe0, rdy1, sbe1;

    lvds_clk_sync #(.SYNC_STAGES(S0), .LOCK_EDGES(L0), .TIMEOUT(T0)) dut0 (
        .i_ddr_clk(clk), .i_rst(rst), .i_sys_clk(sys),
        .o_lvds_ready_ddr(rdy0), .o_data_sbe_ddr(sbe0)
    );

    lvds_clk_sync #(.SYNC_STAGES(S1), .LOCK_EDGES(L1), .TIMEOUT(T1)) dut1 (
        .i_ddr_clk(clk), .i_rst(rst), .i_sys_clk(sys),
        .o_lvds_ready_ddr(rdy1), .o_data_sbe_ddr(sbe1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r0;
        logic s0;
        logic r1;
        logic s1;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: edge index since reset release, edge of last detection,
    // qualifying-edge count and lock flag; hist holds the level sampled at each edge.
    int m_edge[2];
    int m_last[2];
    int m_cnt[2];
    bit m_rdy[2];
    bit hist[2][0:HIST-1];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_edge[i]  = 0;
            m_last[i]  = 0;
            m_cnt[i]   = 0;
            m_rdy[i]   = 1'b0;
            hist[i][0] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int idx, input int ns, input int nl, input int nt,
                                       input bit v, output bit r, output bit sb);
        int k;
        bit det;
        m_edge[idx] = m_edge[idx] + 1;
        if (m_edge[idx] < HIST) hist[idx][m_edge[idx]] = v;
        k   = m_edge[idx] - ns;
        det = (k >= 1) && (k < HIST) && hist[idx][k] && !hist[idx][k-1];
        sb  = det && m_rdy[idx];
        if (det) begin
            m_last[idx] = m_edge[idx];
            if (m_cnt[idx] < nl) m_cnt[idx] = m_cnt[idx] + 1;
            if (!m_rdy[idx] && m_cnt[idx] == nl) m_rdy[idx] = 1'b1;
        end else if (m_edge[idx] - m_last[idx] == nt) begin
            m_cnt[idx] = 0;
            m_rdy[idx] = 1'b0;
        end
        r = m_rdy[idx];
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit v, input int n);
        exp_t e;
        bit r, sb;
        repeat (n) begin
            @(negedge clk);
            sys = v;
            model_step(0, S0, L0, T0, v, r, sb);
            e.r0 = r; e.s0 = sb;
            model_step(1, S1, L1, T1, v, r, sb);
            e.r1 = r; e.s1 = sb;
            exp_q.push_back(e);
        end
    endtask

    task automatic toggle(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    // Asserts reset mid-cycle and checks that outputs clear before the next clock edge
    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sys = 1'b0;
        #1;
        check("rst_ready0", rdy0, 1'b0);
        check("rst_sbe0",   sbe0, 1'b0);
        check("rst_ready1", rdy1, 1'b0);
        check("rst_sbe1",   sbe1, 1'b0);
        repeat (hold) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int pick_len();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6)      return int'($urandom_range(2, 5));
        else if (r < 8) return int'($urandom_range(2, 40));
        else            return int'($urandom_range(14, 18));
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready0", rdy0, e.r0);
                check("sbe0",   sbe0, e.s0);
                check("ready1", rdy1, e.r1);
                check("sbe1",   sbe1, e.s1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, queue depth %0d, expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        async_reset(3);
        drive(1'b0, 100);

        toggle(4, 4, 20);
        drive(1'b1, 40);
        drive(1'b0, 4);
        toggle(4, 4, 12);

        toggle(16, 16, 3);
        toggle(17, 16, 1);
        toggle(4, 4, 10);
        toggle(16, 15, 2);
        toggle(2, 2, 6);
        toggle(2, 3, 3);
        toggle(2, 8, 2);

        repeat (300) begin
            int hi, lo;
            hi = pick_len();
            lo = pick_len();
            drive(1'b1, hi);
            drive(1'b0, lo);
        end

        toggle(4, 4, 12);
        async_reset(2);
        drive(1'b0, 100);
        toggle(4, 4, 12);
        toggle(3, 5, 6);

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
